// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth_sweep truth-table evaluator.
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MODE_BINARY = 0;
    localparam int MODE_GRAY   = 1;

    // Legal range of the function input count N.
    localparam int N_MIN = 1;
    localparam int N_MAX = 6;

    function automatic logic [N_MAX-1:0] gray_of(input logic [N_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/truth_sweep_enc.sv
// Index-to-vector encoder: binary pass-through or reflected Gray, chosen by MODE.
module truth_sweep_enc
    import truth_sweep_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = MODE_BINARY
) (
    input  logic [N-1:0] i_idx,
    output logic [N-1:0] o_vec
);

    logic [N_MAX-1:0] w_idx_wide;
    logic [N_MAX-1:0] w_gray_wide;

    assign w_idx_wide  = N_MAX'(i_idx);
    assign w_gray_wide = gray_of(w_idx_wide);

    generate
        if (MODE == MODE_GRAY) begin : g_gray
            assign o_vec = w_gray_wide[N-1:0];
        end else begin : g_bin
            assign o_vec = i_idx;
        end
    endgenerate

    logic w_unused;
    assign w_unused = ^{w_gray_wide};

endmodule

// File: rtl/truth_sweep.sv
// Sequential N-input truth-table sweeper with valid/ready output and minterm count.
// Optional abort input enabled by defining TRUTH_SWEEP_ABORT_EN.
module truth_sweep
    import truth_sweep_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = MODE_BINARY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [(1<<N)-1:0]  tt_in,
`ifdef TRUTH_SWEEP_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_vec,
    output logic               out_s,
    output logic               done,
    output logic [N:0]         ones_count
);

    localparam int TT_W = 1 << N;

    state_t            r_state;
    state_t            w_next_state;
    logic [TT_W-1:0]   r_tt;
    logic [N-1:0]      r_idx;
    logic              r_last;
    logic [N-1:0]      r_out_vec;
    logic              r_out_s;
    logic [N:0]        r_ones;
    logic              r_busy;
    logic              r_out_valid;
    logic              r_done;

    logic              w_abort;
    logic              w_xfer;
    logic              w_load;
    logic [N-1:0]      w_idx_nxt;
    logic [N-1:0]      w_vec_nxt;

`ifdef TRUTH_SWEEP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_idx_nxt = r_idx + 1'b1;

    // The lookahead vector lets out_s be a registered lookup aligned with out_vec.
    truth_sweep_enc #(
        .N    (N),
        .MODE (MODE)
    ) u_enc (
        .i_idx (w_idx_nxt),
        .o_vec (w_vec_nxt)
    );

    always_comb begin
        w_next_state = r_state;
        w_xfer       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous ready: the in-flight vector is dropped.
                if (w_abort) begin
                    w_next_state = ST_DONE;
                end else if (out_ready) begin
                    w_xfer = 1'b1;
                    if (r_last) w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_out_valid <= (w_next_state == ST_RUN);
            r_done      <= (w_next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt      <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_out_vec <= '0;
            r_out_s   <= 1'b0;
            r_ones    <= '0;
        end else if (w_load) begin
            r_tt      <= tt_in;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_out_vec <= '0;
            r_out_s   <= tt_in[0];
            r_ones    <= '0;
        end else if (w_xfer) begin
            r_ones <= r_ones + {{N{1'b0}}, r_out_s};
            // After the final transfer the index parks instead of wrapping.
            if (!r_last) begin
                r_idx     <= w_idx_nxt;
                r_last    <= &w_idx_nxt;
                r_out_vec <= w_vec_nxt;
                r_out_s   <= r_tt[w_vec_nxt];
            end
        end
    end

    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_vec    = r_out_vec;
    assign out_s      = r_out_s;
    assign done       = r_done;
    assign ones_count = r_ones;

endmodule

// File: tb/tb_truth_sweep.sv
// Directed bench for truth_sweep: binary/Gray sweeps, backpressure, reset, N=1 and N=6 boundaries.
module tb_truth_sweep;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Shared stimulus for the two N=3 instances; sel picks which one sees start.
    logic       sel;
    logic       s3_start;
    logic [7:0] s3_tt;
    logic       s3_ready;
    logic       b_start, g_start;

    assign b_start = ~sel & s3_start;
    assign g_start =  sel & s3_start;

    logic       b_busy, b_valid, b_s, b_done;
    logic [2:0] b_vec;
    logic [3:0] b_ones;
    logic       g_busy, g_valid, g_s, g_done;
    logic [2:0] g_vec;
    logic [3:0] g_ones;

    logic       m_busy, m_valid, m_s, m_done;
    logic [2:0] m_vec;
    logic [3:0] m_ones;
    assign m_busy  = sel ? g_busy  : b_busy;
    assign m_valid = sel ? g_valid : b_valid;
    assign m_s     = sel ? g_s     : b_s;
    assign m_done  = sel ? g_done  : b_done;
    assign m_vec   = sel ? g_vec   : b_vec;
    assign m_ones  = sel ? g_ones  : b_ones;

`ifdef TRUTH_SWEEP_ABORT_EN
    logic b_abort;
`endif

    truth_sweep #(.N(3), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .tt_in(s3_tt),
`ifdef TRUTH_SWEEP_ABORT_EN
        .abort(b_abort),
`endif
        .busy(b_busy), .out_valid(b_valid), .out_ready(s3_ready),
        .out_vec(b_vec), .out_s(b_s), .done(b_done), .ones_count(b_ones)
    );

    truth_sweep #(.N(3), .MODE(1)) u_g (
        .clk(clk), .rst_n(rst_n), .start(g_start), .tt_in(s3_tt),
`ifdef TRUTH_SWEEP_ABORT_EN
        .abort(1'b0),
`endif
        .busy(g_busy), .out_valid(g_valid), .out_ready(s3_ready),
        .out_vec(g_vec), .out_s(g_s), .done(g_done), .ones_count(g_ones)
    );

    logic       n1_start, n1_ready;
    logic [1:0] n1_tt;
    logic       n1_busy, n1_valid, n1_s, n1_done;
    logic [0:0] n1_vec;
    logic [1:0] n1_ones;

    truth_sweep #(.N(1), .MODE(0)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(n1_start), .tt_in(n1_tt),
`ifdef TRUTH_SWEEP_ABORT_EN
        .abort(1'b0),
`endif
        .busy(n1_busy), .out_valid(n1_valid), .out_ready(n1_ready),
        .out_vec(n1_vec), .out_s(n1_s), .done(n1_done), .ones_count(n1_ones)
    );

    logic        n6_start, n6_ready;
    logic [63:0] n6_tt;
    logic        n6_busy, n6_valid, n6_s, n6_done;
    logic [5:0]  n6_vec;
    logic [6:0]  n6_ones;

    truth_sweep #(.N(6), .MODE(0)) u_n6 (
        .clk(clk), .rst_n(rst_n), .start(n6_start), .tt_in(n6_tt),
`ifdef TRUTH_SWEEP_ABORT_EN
        .abort(1'b0),
`endif
        .busy(n6_busy), .out_valid(n6_valid), .out_ready(n6_ready),
        .out_vec(n6_vec), .out_s(n6_s), .done(n6_done), .ones_count(n6_ones)
    );

    // Hand-derived expectations for tt = 8'h30 (true only at vectors 100 and 101).
    logic [2:0] bin_vec [8];
    logic       bin_s   [8];
    logic [2:0] gry_vec [8];
    logic       gry_s   [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the chosen N=3 instance idle.
    task automatic sweep3(input logic g, input logic [7:0] tt, input int stall_at,
                          input int stall_len, input logic poke, input int exp_ones);
        int k, stall, cyc;
        sel = g; s3_tt = tt; s3_start = 1'b1; s3_ready = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        k = 0; stall = 0; cyc = 0;
        while (k < 8 && cyc < 40) begin
            chk("valid", 32'(m_valid), 32'd1);
            chk("busy",  32'(m_busy),  32'd1);
            chk("vec",   32'(m_vec),   32'(g ? gry_vec[k] : bin_vec[k]));
            chk("s",     32'(m_s),     32'(g ? gry_s[k]   : bin_s[k]));
            if (poke && k == 3) begin
                s3_tt = 8'hFF; s3_start = 1'b1;
            end else begin
                s3_start = 1'b0;
            end
            if (k == stall_at && stall < stall_len) begin
                s3_ready = 1'b0; stall++;
            end else begin
                s3_ready = 1'b1; k++;
            end
            @(negedge clk);
            cyc++;
        end
        s3_start = 1'b0; s3_ready = 1'b1;
        chk("sweep_len",  32'(k),       32'd8);
        chk("done_pulse", 32'(m_done),  32'd1);
        chk("done_valid", 32'(m_valid), 32'd0);
        chk("done_busy",  32'(m_busy),  32'd1);
        chk("ones",       32'(m_ones),  32'(exp_ones));
        @(negedge clk);
        chk("done_clear", 32'(m_done),  32'd0);
        chk("idle_busy",  32'(m_busy),  32'd0);
        chk("ones_hold",  32'(m_ones),  32'(exp_ones));
    endtask

    task automatic sweep1(input logic [1:0] tt, input int exp_ones);
        n1_tt = tt; n1_start = 1'b1; n1_ready = 1'b1;
        @(negedge clk);
        n1_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("n1_valid", 32'(n1_valid), 32'd1);
            chk("n1_vec",   32'(n1_vec),   32'(k));
            chk("n1_s",     32'(n1_s),     32'(tt == 2'b11));
            @(negedge clk);
        end
        chk("n1_done", 32'(n1_done), 32'd1);
        chk("n1_ones", 32'(n1_ones), 32'(exp_ones));
        @(negedge clk);
    endtask

    initial begin
        bin_vec = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        bin_s   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        gry_vec = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        gry_s   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; sel = 1'b0; s3_start = 1'b0; s3_tt = 8'h00; s3_ready = 1'b1;
        n1_start = 1'b0; n1_tt = 2'b00; n1_ready = 1'b1;
        n6_start = 1'b0; n6_tt = '0; n6_ready = 1'b1;
`ifdef TRUTH_SWEEP_ABORT_EN
        b_abort = 1'b0;
`endif
        @(negedge clk);
        chk("rst_busy",  32'(b_busy),  32'd0);
        chk("rst_valid", 32'(b_valid), 32'd0);
        chk("rst_vec",   32'(b_vec),   32'd0);
        chk("rst_s",     32'(b_s),     32'd0);
        chk("rst_done",  32'(b_done),  32'd0);
        chk("rst_ones",  32'(b_ones),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep3(1'b0, 8'h30, -1, 0, 1'b0, 2);   // binary, ready high
        sweep3(1'b0, 8'h30,  4, 3, 1'b0, 2);   // 3-cycle stall at vector 100
        sweep3(1'b1, 8'h30, -1, 0, 1'b0, 2);   // Gray order

        // Asynchronous reset while vector 011 is presented.
        sel = 1'b0; s3_tt = 8'h30; s3_start = 1'b1; s3_ready = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("pre_rst_vec", 32'(b_vec), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(b_busy),  32'd0);
        chk("arst_valid", 32'(b_valid), 32'd0);
        chk("arst_vec",   32'(b_vec),   32'd0);
        chk("arst_s",     32'(b_s),     32'd0);
        chk("arst_done",  32'(b_done),  32'd0);
        chk("arst_ones",  32'(b_ones),  32'd0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'(b_done), 32'd0);
            chk("idle_after_rst",    32'(b_busy), 32'd0);
        end

        // Mid-sweep start with a new table must be ignored.
        sweep3(1'b0, 8'h30, -1, 0, 1'b1, 2);

        sweep1(2'b00, 0);
        sweep1(2'b11, 2);

        n6_tt = {64{1'b1}}; n6_start = 1'b1;
        @(negedge clk);
        n6_start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k == 0 || k == 31 || k == 63) begin
                chk("n6_vec", 32'(n6_vec), 32'(k));
                chk("n6_s",   32'(n6_s),   32'd1);
            end
            @(negedge clk);
        end
        chk("n6_done", 32'(n6_done), 32'd1);
        chk("n6_ones", 32'(n6_ones), 32'd64);
        @(negedge clk);

`ifdef TRUTH_SWEEP_ABORT_EN
        sel = 1'b0; s3_tt = 8'h30; s3_start = 1'b1; s3_ready = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("abort_vec", 32'(b_vec), 32'd5);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        chk("abort_done",  32'(b_done),  32'd1);
        chk("abort_valid", 32'(b_valid), 32'd0);
        chk("abort_ones",  32'(b_ones),  32'd1);
        @(negedge clk);
        chk("abort_idle",  32'(b_busy),  32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_sweep.md
# truth_sweep

Sequential, parametrised truth-table evaluator: the next generation of our fixed three-input Boolean-expression blocks. It accepts any N-input function as a 2^N-bit truth table and walks every input combination in binary or Gray order. For each combination it streams the input vector and function value over a valid/ready handshake, then reports the count of true minterms. It sits between a stimulus/config source and a checker or logger, replacing per-expression modules plus their hand-written sweep benches.

## Interface
- N, default 3: number of function inputs; legal range 1..6.
- MODE, default 0: 0 = ascending binary order; 1 = reflected Gray order.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- tt_in  input  2^N  truth table; bit i = f(vector i); captured on accepted start.
- busy  output  1  high in RUN and DONE.
- out_valid  output  1  out_vec/out_s hold a valid combination.
- out_ready  input  1  consumer accepts the current combination.
- out_vec  output  N  input combination; bit N-1 = first variable (x), bit 0 = last.
- out_s  output  1  f(out_vec) = captured tt[out_vec].
- done  output  1  one-cycle pulse after the last transfer.
- ones_count  output  N+1  number of true minterms in the completed sweep.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures tt_in, clears the index counter and ones_count, and moves to RUN.
- RUN: out_valid=1. out_vec = idx (MODE 0) or idx ^ (idx>>1) (MODE 1). out_s = tt[out_vec].
- RUN transfer: valid & ready is a transfer. Each transfer increments idx and adds out_s to ones_count.
- RUN exit: the transfer at idx = 2^N-1 moves to DONE; idx does not wrap into a second pass.
- DONE: out_valid=0 and done=1 for one cycle, then return to IDLE.
- ones_count holds its value until the next accepted start.
- start is ignored in RUN and DONE; a captured table cannot change mid-sweep.
- Without a transfer, out_vec/out_s stay stable while out_valid=1 (standard valid/ready: valid never drops before a transfer).
- Arithmetic: idx is N bits wide plus a terminal flag; ones_count is N+1 bits, enough for 2^N.

## Timing
- Reset values: busy=0, out_valid=0, out_vec=0, out_s=0, done=0, ones_count=0; state IDLE; captured table=0.
- Reset mid-sweep: all of the above take effect immediately (asynchronous); the sweep is lost and no done is issued.
- Start latency: start in cycle t gives out_valid=1 with the first vector in cycle t+1.
- Throughput: with out_ready held high, one combination per cycle. A full sweep takes 2^N cycles in RUN plus 1 in DONE.
- Outputs are registered; out_s may be a registered table lookup, but it must align with out_vec in the same cycle.
- Earliest restart: the cycle after DONE.

## Configuration
- TRUTH_SWEEP_ABORT_EN defined: adds input abort (1 bit).
  - abort=1 in RUN forces DONE next cycle; done pulses and ones_count reflects transfers completed so far.
  - The vector in flight during the abort cycle is not transferred, even if out_ready=1.
  - abort is ignored in IDLE and DONE.
- Macro undefined: the port does not exist, and every sweep runs to completion.

## Structure
- Package truth_sweep_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - MODE constants MODE_BINARY=0 and MODE_GRAY=1;
  - N range limits.
- Sub-module truth_sweep_enc: combinational index-to-vector encoder (binary pass-through or Gray), parametrised by N and MODE.
- The FSM, counter and table register live in the top.

## Test plan
- Ready always high, N=3, MODE=0, tt_in=8'h30 (x·y'): vectors 000..111 on consecutive cycles.
  - out_s = 0,0,0,0,1,1,0,0.
  - done pulses one cycle after vector 111; ones_count=2.
- Backpressure, same table: out_ready low for 3 cycles at vector 100.
  - out_vec=100 and out_s=1 hold stable, and no duplicate or skipped vectors appear.
- Gray order, N=3, MODE=1, tt_in=8'h30: vectors 000,001,011,010,110,111,101,100.
  - out_s = 0,0,0,0,0,0,1,1; ones_count=2.
- Reset and start during RUN:
  - rst_n low at vector 011 clears all outputs immediately; no done follows.
  - After restart, start pulses during RUN do not reload tt_in (change tt_in to 8'hFF mid-sweep; ones_count stays 2).
- Boundary tables, N=1: tt_in=2'b00 gives ones_count=0; tt_in=2'b11 gives ones_count=2 (full N+1 width).
  - N=6: all-ones table gives ones_count=64.
- With TRUTH_SWEEP_ABORT_EN, N=3, tt=8'h30, ready high: abort while vector 101 is presented.
  - Transfers 000..100 completed, so ones_count=1.
  - done pulses the next cycle, and 101 is never transferred.
